reg_read_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single 32-bit 16:1 register read mux (Mux16to1) among NUM_REQ requesters.
- Each cycle it grants at most one requester, drives the mux select with that requester's register address, captures the mux output and returns it tagged with the requester ID.
- Sits between the register bank plus Mux16to1 and the read clients (fetch, ALU operand fetch, debug port).

---
 rtl/reg_read_arbiter.sv | 114 +++++++++++
 tb/tb_reg_read_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter that shares one 16:1 register read mux among NUM_REQ requesters.
// Grants are combinational; the select and the returned data are pipelined over two stages.
module reg_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [ADDR_WIDTH-1:0]          mux_sel,
    input  logic [DATA_WIDTH-1:0]          mux_out,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic [ID_WIDTH-1:0]            rd_id
);

    logic [ID_WIDTH-1:0]   rr_ptr_q,   rr_ptr_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [ID_WIDTH-1:0]   s1_id_q,    s1_id_d;
    logic [ADDR_WIDTH-1:0] mux_sel_q,  mux_sel_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ID_WIDTH-1:0]   rd_id_q,    rd_id_d;

    logic                  grant_s;
    logic [ID_WIDTH-1:0]   win_s;
    logic [ID_WIDTH-1:0]   cand_s;
    logic [NUM_REQ-1:0]    gnt_s;

    // Round-robin search from rr_ptr; index arithmetic wraps because NUM_REQ == 2**ID_WIDTH.
    always_comb begin
        grant_s = 1'b0;
        win_s   = rr_ptr_q;
        cand_s  = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = rr_ptr_q + ID_WIDTH'(k);
            if (!grant_s && req[cand_s]) begin
                grant_s = 1'b1;
                win_s   = cand_s;
            end else begin
                grant_s = grant_s;
            end
        end
        if (reset) begin
            grant_s = 1'b0;
        end else begin
            grant_s = grant_s;
        end
        if (grant_s) begin
            gnt_s = NUM_REQ'(1) << win_s;
        end else begin
            gnt_s = {NUM_REQ{1'b0}};
        end
    end

    // Next-state for the pointer, the select stage and the data-return stage.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = 1'b0;
        s1_id_d    = s1_id_q;
        mux_sel_d  = mux_sel_q;
        rd_data_d  = rd_data_q;
        rd_id_d    = rd_id_q;
        rd_valid_d = 1'b0;
        if (grant_s) begin
            rr_ptr_d   = win_s + ID_WIDTH'(1);
            s1_valid_d = 1'b1;
            s1_id_d    = win_s;
            mux_sel_d  = addr[win_s*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
            s1_valid_d = 1'b0;
        end
        // mux_out already reflects mux_sel_q, so stage 2 captures the granted register.
        if (s1_valid_q) begin
            rd_data_d  = mux_out;
            rd_id_d    = s1_id_q;
            rd_valid_d = 1'b1;
        end else begin
            rd_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that also flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= {ID_WIDTH{1'b0}};
            s1_valid_q <= 1'b0;
            s1_id_q    <= {ID_WIDTH{1'b0}};
            mux_sel_q  <= {ADDR_WIDTH{1'b0}};
            rd_data_q  <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
            rd_id_q    <= {ID_WIDTH{1'b0}};
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            mux_sel_q  <= mux_sel_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    assign gnt      = gnt_s;
    assign mux_sel  = mux_sel_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Scoreboard bench for reg_read_arbiter: a round-robin reference model predicts grants,
// mux select and returned reads; a monitor process checks every output cycle.
module tb_reg_read_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [15:0] addr = 16'd0;
    logic [3:0]  gnt;
    logic [3:0]  mux_sel;
    logic [31:0] mux_out;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [1:0]  rd_id;

    always #5 clk = ~clk;

    // Register bank behind the mux holds 0x100+k in register k.
    assign mux_out = 32'h100 + {28'h0, mux_sel};

    reg_read_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .addr     (addr),
        .gnt      (gnt),
        .mux_sel  (mux_sel),
        .mux_out  (mux_out),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_id    (rd_id)
    );

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic rst_prev = 1'b0;

    int          m_ptr = 0;
    logic [3:0]  m_sel = 4'd0;
    bit          sel_known = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    task automatic step(input logic [3:0] r, input logic [15:0] a, input logic rst);
        int         w;
        logic [3:0] eg;
        logic [3:0] wa;
        @(posedge clk);
        #1;
        req   = r;
        addr  = a;
        reset = rst;
        @(negedge clk);
        if (sel_known) chk("mux_sel", {28'h0, mux_sel}, {28'h0, m_sel});
        w  = rst ? -1 : pick(r, m_ptr);
        eg = (w < 0) ? 4'd0 : 4'(1 << w);
        chk("gnt", {28'h0, gnt}, {28'h0, eg});
        if (rst) begin
            m_ptr     = 0;
            m_sel     = 4'd0;
            sel_known = 1'b1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due > cyc) sb.delete(i);
            end
        end else if (w >= 0) begin
            wa    = a[w*4 +: 4];
            m_ptr = (w + 1) % 4;
            m_sel = wa;
            sb.push_back('{due: cyc + 2, id: w, data: 32'h100 + {28'h0, wa}});
        end
    endtask

    // Monitor: compares the read-return port against the scoreboard every cycle.
    initial begin
        bit          known;
        logic [31:0] last_data;
        logic [1:0]  last_id;
        exp_t        e;
        known     = 1'b0;
        last_data = 32'd0;
        last_id   = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_prev) known = 1'b1;
            if (known) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    e = sb.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_read cycle %0d: got nothing expected id %0d data %h", cyc, e.id, e.data);
                end
                if (rst_prev) begin
                    chk("rd_valid_rst", {31'h0, rd_valid}, 32'd0);
                    chk("rd_data_rst", rd_data, 32'd0);
                    chk("rd_id_rst", {30'h0, rd_id}, 32'd0);
                    last_data = 32'd0;
                    last_id   = 2'd0;
                end else if (sb.size() > 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("rd_valid", {31'h0, rd_valid}, 32'd1);
                    chk("rd_data", rd_data, e.data);
                    chk("rd_id", {30'h0, rd_id}, 32'(e.id));
                    last_data = e.data;
                    last_id   = 2'(e.id);
                end else begin
                    chk("rd_valid_idle", {31'h0, rd_valid}, 32'd0);
                    chk("rd_data_hold", rd_data, last_data);
                    chk("rd_id_hold", {30'h0, rd_id}, {30'h0, last_id});
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        // Reset then idle
        step(4'b0000, 16'h0000, 1'b1);
        step(4'b0000, 16'h0000, 1'b1);
        repeat (5) step(4'b0000, 16'h0000, 1'b0);
        // Single read from requester 1, register 7
        step(4'b0010, 16'h0070, 1'b0);
        repeat (3) step(4'b0000, 16'h0000, 1'b0);
        // Saturation after a fresh reset, addresses 3,5,9,15
        step(4'b1111, 16'hF953, 1'b1);
        repeat (8) step(4'b1111, 16'hF953, 1'b0);
        // Pointer wrap from 3 back to 0
        repeat (3) step(4'b0101, 16'h0B0A, 1'b0);
        repeat (2) step(4'b0000, 16'h0000, 1'b0);
        // Address sweep by requester 2
        for (int i = 0; i < 16; i++) begin
            a = 16'(i) << 8;
            step(4'b0100, a, 1'b0);
        end
        repeat (2) step(4'b0000, 16'h0000, 1'b0);
        // Reset mid-flight, with requests present during reset
        step(4'b1000, 16'hC000, 1'b0);
        step(4'b1111, 16'h1234, 1'b1);
        repeat (4) step(4'b1111, 16'h1234, 1'b0);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            step(4'b0000, 16'h0000, 1'b0);
        end
        step(4'b0000, 16'h0000, 1'b0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
